// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle for the FIFO write-port arbiter.
// The master modport is the environment side; the slave modport is the arbiter side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] w_data_in;
  logic                   fifo_full;
  logic [N_REQ-1:0]       gnt;
  logic                   fifo_wr_en;
  logic [WIDTH-1:0]       fifo_w_data;
  logic [ID_W-1:0]        owner;
  logic                   busy;

  modport master (
    output req, w_data_in, fifo_full,
    input  gnt, fifo_wr_en, fifo_w_data, owner, busy
  );

  modport slave (
    input  req, w_data_in, fifo_full,
    output gnt, fifo_wr_en, fifo_w_data, owner, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among N_REQ producers.
// gnt, fifo_wr_en and fifo_w_data are combinational from state, req and fifo_full.
module fifo_wr_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [ID_W-1:0]  owner_q, owner_nxt;
  logic [ID_W-1:0]  last_q, last_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  idx;
  logic [WIDTH-1:0] sel_data;
  logic             accept;
  logic             last_beat;

  // Round-robin search from last+1; iterating downward lets the nearest requester win.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      idx = ID_W'((int'(last_q) + k) % int'(N_REQ));
      if (bus.req[idx]) pick = idx;
    end
  end

  // Data slice of the current owner.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (owner_q == ID_W'(i)) sel_data = bus.w_data_in[i*int'(WIDTH) +: WIDTH];
    end
  end

  assign accept    = (state == GRANT) & bus.req[owner_q] & ~bus.fifo_full & ~rst;
  assign last_beat = (cnt_q == CNT_W'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      owner_q <= '0;
      last_q  <= ID_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state   <= state_nxt;
      owner_q <= owner_nxt;
      last_q  <= last_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner_q;
    last_nxt        = last_q;
    cnt_nxt         = cnt_q;
    bus.gnt         = '0;
    bus.fifo_wr_en  = accept;
    bus.fifo_w_data = '0;
    bus.owner       = owner_q;
    bus.busy        = (state == GRANT);

    if (accept) begin
      bus.gnt         = N_REQ'(1) << owner_q;
      bus.fifo_w_data = sel_data;
    end

    case (state)
      IDLE: begin
        if (|bus.req) begin
          owner_nxt = pick;
          cnt_nxt   = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // Owner withdrawal ends the burst; a full FIFO simply stalls it.
        if (!bus.req[owner_q]) begin
          last_nxt  = owner_q;
          state_nxt = IDLE;
        end else if (accept) begin
          cnt_nxt = cnt_q + CNT_W'(1);
          if (last_beat) begin
            last_nxt  = owner_q;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a
// transaction-level model that counts remaining beats per burst.
module tb_fifo_wr_arbiter;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) bus0 ();
  fifo_wr_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) bus1 ();

  fifo_wr_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W), .MAX_BURST(4), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  fifo_wr_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W), .MAX_BURST(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Model state: in a burst or not, who owns it, beats still allowed, previous owner.
  int m_busy[2], m_owner[2], m_left[2], m_last[2];
  int n_busy[2], n_owner[2], n_left[2], n_last[2];
  logic [3:0] exp_gnt[2];
  logic       exp_wr[2];
  logic [7:0] exp_data[2];
  logic [1:0] exp_owner[2];
  logic       exp_busy[2];
  logic [3:0] obs_gnt[2];
  logic       obs_wr0;
  int         fifo_cnt;
  logic       pop;
  logic       refresh;

  function automatic int max_burst(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic eval(input int d, input logic [3:0] r, input logic f, input logic [31:0] din);
    int o;
    bit hit;
    bit found;
    o   = m_owner[d];
    hit = (m_busy[d] != 0) && r[o] && !f && !rst;
    exp_busy[d]  = (m_busy[d] != 0);
    exp_owner[d] = 2'(o);
    exp_wr[d]    = hit;
    exp_gnt[d]   = hit ? 4'(1 << o) : 4'b0000;
    exp_data[d]  = hit ? din[o*8 +: 8] : 8'h00;
    n_busy[d] = m_busy[d]; n_owner[d] = m_owner[d];
    n_left[d] = m_left[d]; n_last[d] = m_last[d];
    if (rst) begin
      n_busy[d] = 0; n_owner[d] = 0; n_last[d] = N_REQ - 1; n_left[d] = max_burst(d);
    end else if (m_busy[d] == 0) begin
      found = 0;
      for (int k = 1; k <= int'(N_REQ); k++) begin
        if (!found && r[(m_last[d] + k) % N_REQ]) begin
          found = 1;
          n_owner[d] = (m_last[d] + k) % N_REQ;
          n_busy[d] = 1;
          n_left[d] = max_burst(d);
        end
      end
    end else if (!r[o]) begin
      n_busy[d] = 0; n_last[d] = o;
    end else if (hit) begin
      n_left[d] = m_left[d] - 1;
      if (n_left[d] == 0) begin
        n_busy[d] = 0; n_last[d] = o;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    eval(0, bus0.req, bus0.fifo_full, bus0.w_data_in);
    eval(1, bus1.req, bus1.fifo_full, bus1.w_data_in);
    obs_gnt[0] = bus0.gnt;
    obs_gnt[1] = bus1.gnt;
    obs_wr0    = bus0.fifo_wr_en;
  endtask

  task automatic advance();
    bit popped;
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = n_busy[d]; m_owner[d] = n_owner[d];
      m_left[d] = n_left[d]; m_last[d] = n_last[d];
    end
    popped   = pop && (fifo_cnt > 0);
    fifo_cnt = fifo_cnt + (obs_wr0 ? 1 : 0) - (popped ? 1 : 0);
    bus0.fifo_full = (fifo_cnt >= DEPTH);
    if (refresh) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (obs_gnt[0][i]) bus0.w_data_in[i*8 +: 8] = 8'($urandom);
        if (obs_gnt[1][i]) bus1.w_data_in[i*8 +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    settle();
    advance();
    rst = 1'b0;
    fifo_cnt = 0;
    bus0.fifo_full = 1'b0;
  endtask

  task automatic test_reset();
    bus0.req = 4'b1111;
    do_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle();
      n_chk++;
      if ({bus0.gnt, bus0.fifo_wr_en, bus0.fifo_w_data, bus0.owner, bus0.busy} !==
          {4'b0000, 1'b0, 8'h00, 2'd0, 1'b0})
        $display("FAIL reset cyc=%0d got gnt=%b wr=%b data=%h owner=%0d busy=%b want all zero",
                 cyc, bus0.gnt, bus0.fifo_wr_en, bus0.fifo_w_data, bus0.owner, bus0.busy);
      else n_pass++;
      advance();
      rst = 1'b0;
    end
    do_reset();
    bus0.req = 4'b0000;
  endtask

  task automatic test_single();
    logic [5:0] pat;
    int writes;
    pat = 6'b011110;
    writes = 0;
    refresh = 1'b0;
    pop = 1'b1;
    do_reset();
    bus0.req = 4'b0001;
    bus0.w_data_in = 32'h0000_00A5;
    for (int c = 0; c < 6; c++) begin
      settle();
      n_chk++;
      if ({bus0.gnt, bus0.fifo_wr_en, bus0.fifo_w_data, bus0.owner, bus0.busy} !==
          {exp_gnt[0], exp_wr[0], exp_data[0], exp_owner[0], exp_busy[0]})
        $display("FAIL single cyc=%0d got gnt=%b wr=%b data=%h owner=%0d busy=%b want gnt=%b wr=%b data=%h owner=%0d busy=%b",
                 cyc, bus0.gnt, bus0.fifo_wr_en, bus0.fifo_w_data, bus0.owner, bus0.busy,
                 exp_gnt[0], exp_wr[0], exp_data[0], exp_owner[0], exp_busy[0]);
      else n_pass++;
      n_chk++;
      if (bus0.fifo_wr_en !== pat[c])
        $display("FAIL single_pattern c=%0d got wr=%b want %b", c, bus0.fifo_wr_en, pat[c]);
      else n_pass++;
      if (bus0.fifo_wr_en === 1'b1) writes++;
      advance();
    end
    n_chk++;
    if (writes != 4) $display("FAIL single_count got %0d writes want 4", writes);
    else n_pass++;
    bus0.req = 4'b0000;
    refresh = 1'b1;
  endtask

  task automatic test_stream();
    int writes;
    writes = 0;
    pop = 1'b1;
    do_reset();
    bus0.req = 4'b1111;
    bus0.w_data_in = $urandom;
    for (int c = 0; c < 22; c++) begin
      settle();
      n_chk++;
      if ({bus0.gnt, bus0.fifo_wr_en, bus0.fifo_w_data, bus0.owner, bus0.busy} !==
          {exp_gnt[0], exp_wr[0], exp_data[0], exp_owner[0], exp_busy[0]})
        $display("FAIL stream cyc=%0d got gnt=%b wr=%b data=%h owner=%0d busy=%b want gnt=%b wr=%b data=%h owner=%0d busy=%b",
                 cyc, bus0.gnt, bus0.fifo_wr_en, bus0.fifo_w_data, bus0.owner, bus0.busy,
                 exp_gnt[0], exp_wr[0], exp_data[0], exp_owner[0], exp_busy[0]);
      else n_pass++;
      if (c < 20 && bus0.fifo_wr_en === 1'b1) begin
        n_chk++;
        if (bus0.owner !== 2'(writes / 4))
          $display("FAIL stream_owner beat=%0d got owner=%0d want %0d", writes, bus0.owner, writes / 4);
        else n_pass++;
        writes++;
      end
      advance();
    end
    n_chk++;
    if (writes != 16) $display("FAIL stream_count got %0d beats in 20 cycles want 16", writes);
    else n_pass++;
    bus0.req = 4'b0000;
  endtask

  task automatic test_drop();
    int writes2;
    writes2 = 0;
    pop = 1'b1;
    do_reset();
    bus0.req = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) bus0.req = 4'b1000;
      settle();
      n_chk++;
      if ({bus0.gnt, bus0.fifo_wr_en, bus0.fifo_w_data, bus0.owner, bus0.busy} !==
          {exp_gnt[0], exp_wr[0], exp_data[0], exp_owner[0], exp_busy[0]})
        $display("FAIL drop cyc=%0d got gnt=%b wr=%b data=%h owner=%0d busy=%b want gnt=%b wr=%b data=%h owner=%0d busy=%b",
                 cyc, bus0.gnt, bus0.fifo_wr_en, bus0.fifo_w_data, bus0.owner, bus0.busy,
                 exp_gnt[0], exp_wr[0], exp_data[0], exp_owner[0], exp_busy[0]);
      else n_pass++;
      if (bus0.gnt === 4'b0100) writes2++;
      if (c == 5) begin
        n_chk++;
        if (bus0.owner !== 2'd3 || bus0.busy !== 1'b1)
          $display("FAIL drop_next got owner=%0d busy=%b want owner=3 busy=1", bus0.owner, bus0.busy);
        else n_pass++;
      end
      advance();
    end
    n_chk++;
    if (writes2 != 2) $display("FAIL drop_count got %0d writes from port 2 want 2", writes2);
    else n_pass++;
    bus0.req = 4'b0000;
  endtask

  task automatic test_full();
    int writes;
    writes = 0;
    do_reset();
    pop = 1'b0;
    fifo_cnt = DEPTH - 2;
    bus0.req = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      if (c >= 5) pop = 1'b1;
      settle();
      n_chk++;
      if ({bus0.gnt, bus0.fifo_wr_en, bus0.fifo_w_data, bus0.owner, bus0.busy} !==
          {exp_gnt[0], exp_wr[0], exp_data[0], exp_owner[0], exp_busy[0]})
        $display("FAIL full cyc=%0d got gnt=%b wr=%b data=%h owner=%0d busy=%b want gnt=%b wr=%b data=%h owner=%0d busy=%b",
                 cyc, bus0.gnt, bus0.fifo_wr_en, bus0.fifo_w_data, bus0.owner, bus0.busy,
                 exp_gnt[0], exp_wr[0], exp_data[0], exp_owner[0], exp_busy[0]);
      else n_pass++;
      if (c >= 3 && c <= 5) begin
        n_chk++;
        if (bus0.fifo_wr_en !== 1'b0 || bus0.busy !== 1'b1)
          $display("FAIL full_stall c=%0d got wr=%b busy=%b want wr=0 busy=1", c, bus0.fifo_wr_en, bus0.busy);
        else n_pass++;
      end
      if (bus0.fifo_wr_en === 1'b1) writes++;
      advance();
    end
    n_chk++;
    if (writes != 4) $display("FAIL full_count got %0d writes want 4", writes);
    else n_pass++;
    bus0.req = 4'b0000;
    pop = 1'b1;
  endtask

  task automatic test_reset_mid();
    pop = 1'b1;
    do_reset();
    bus0.req = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      rst = (c == 2);
      if (c == 3) bus0.req = 4'b1000;
      settle();
      n_chk++;
      if ({bus0.gnt, bus0.fifo_wr_en, bus0.fifo_w_data, bus0.owner, bus0.busy} !==
          {exp_gnt[0], exp_wr[0], exp_data[0], exp_owner[0], exp_busy[0]})
        $display("FAIL reset_mid cyc=%0d got gnt=%b wr=%b data=%h owner=%0d busy=%b want gnt=%b wr=%b data=%h owner=%0d busy=%b",
                 cyc, bus0.gnt, bus0.fifo_wr_en, bus0.fifo_w_data, bus0.owner, bus0.busy,
                 exp_gnt[0], exp_wr[0], exp_data[0], exp_owner[0], exp_busy[0]);
      else n_pass++;
      if (c == 2) begin
        n_chk++;
        if (bus0.fifo_wr_en !== 1'b0) $display("FAIL reset_mid_write got wr=%b want 0", bus0.fifo_wr_en);
        else n_pass++;
      end
      if (c == 3) begin
        n_chk++;
        if (bus0.owner !== 2'd0 || bus0.busy !== 1'b0)
          $display("FAIL reset_mid_idle got owner=%0d busy=%b want owner=0 busy=0", bus0.owner, bus0.busy);
        else n_pass++;
      end
      if (c == 4) begin
        n_chk++;
        if (bus0.owner !== 2'd3 || bus0.gnt !== 4'b1000)
          $display("FAIL reset_mid_regrant got owner=%0d gnt=%b want owner=3 gnt=1000", bus0.owner, bus0.gnt);
        else n_pass++;
      end
      advance();
    end
    rst = 1'b0;
    bus0.req = 4'b0000;
  endtask

  task automatic test_burst1();
    logic [1:0] seq [4];
    int writes;
    seq = '{2'd0, 2'd2, 2'd0, 2'd2};
    writes = 0;
    do_reset();
    bus1.req = 4'b0101;
    for (int c = 0; c < 8; c++) begin
      settle();
      n_chk++;
      if ({bus1.gnt, bus1.fifo_wr_en, bus1.fifo_w_data, bus1.owner, bus1.busy} !==
          {exp_gnt[1], exp_wr[1], exp_data[1], exp_owner[1], exp_busy[1]})
        $display("FAIL burst1 cyc=%0d got gnt=%b wr=%b data=%h owner=%0d busy=%b want gnt=%b wr=%b data=%h owner=%0d busy=%b",
                 cyc, bus1.gnt, bus1.fifo_wr_en, bus1.fifo_w_data, bus1.owner, bus1.busy,
                 exp_gnt[1], exp_wr[1], exp_data[1], exp_owner[1], exp_busy[1]);
      else n_pass++;
      n_chk++;
      if (bus1.fifo_wr_en !== 1'(c % 2))
        $display("FAIL burst1_bubble c=%0d got wr=%b want %0d", c, bus1.fifo_wr_en, c % 2);
      else n_pass++;
      if (bus1.fifo_wr_en === 1'b1 && writes < 4) begin
        n_chk++;
        if (bus1.owner !== seq[writes])
          $display("FAIL burst1_order grant=%0d got owner=%0d want %0d", writes, bus1.owner, seq[writes]);
        else n_pass++;
        writes++;
      end
      advance();
    end
    bus1.req = 4'b0000;
  endtask

  task automatic test_random();
    pop = 1'b1;
    do_reset();
    bus0.req = 4'($urandom);
    for (int c = 0; c < 600; c++) begin
      settle();
      n_chk++;
      if ({bus0.gnt, bus0.fifo_wr_en, bus0.fifo_w_data, bus0.owner, bus0.busy} !==
          {exp_gnt[0], exp_wr[0], exp_data[0], exp_owner[0], exp_busy[0]})
        $display("FAIL random cyc=%0d got gnt=%b wr=%b data=%h owner=%0d busy=%b want gnt=%b wr=%b data=%h owner=%0d busy=%b",
                 cyc, bus0.gnt, bus0.fifo_wr_en, bus0.fifo_w_data, bus0.owner, bus0.busy,
                 exp_gnt[0], exp_wr[0], exp_data[0], exp_owner[0], exp_busy[0]);
      else n_pass++;
      pop = ($urandom_range(0, 2) != 0);
      advance();
      // Producers only change req after being served, or raise a fresh request.
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (obs_gnt[0][i]) bus0.req[i] = ($urandom_range(0, 9) < 7);
        else if (!bus0.req[i]) bus0.req[i] = ($urandom_range(0, 9) < 3);
      end
      rst = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    bus0.req = '0; bus0.w_data_in = $urandom; bus0.fifo_full = 1'b0;
    bus1.req = '0; bus1.w_data_in = $urandom; bus1.fifo_full = 1'b0;
    pop = 1'b1;
    refresh = 1'b1;
    fifo_cnt = 0;
    test_reset();
    test_single();
    test_stream();
    test_drop();
    test_full();
    test_reset_mid();
    test_burst1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
